// File: rtl/bulls_cows_engine.sv
// Two-player Bulls & Cows game engine: secret entry, alternating guesses,
// equal-turns rule, round limit and saturating per-player win tally.
module bulls_cows_engine #(
    parameter int N_DIGITS   = 4,
    parameter int DIGIT_W    = 4,
    parameter int BASE       = 10,
    parameter int MAX_ROUNDS = 10,
    parameter int SCORE_W    = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [N_DIGITS*DIGIT_W-1:0]   guess,
    input  logic                          confirm,
    output logic [2:0]                    state,
    output logic [$clog2(N_DIGITS+1)-1:0] bulls,
    output logic [$clog2(N_DIGITS+1)-1:0] cows,
    output logic                          result_valid,
    output logic                          reject,
    output logic [7:0]                    round,
    output logic [1:0]                    winner,
    output logic [SCORE_W-1:0]            score_j1,
    output logic [SCORE_W-1:0]            score_j2
);

    localparam int CW = $clog2(N_DIGITS + 1);
    localparam int GW = N_DIGITS * DIGIT_W;
    localparam logic [DIGIT_W:0] BASE_L = (DIGIT_W + 1)'(BASE);
    localparam logic [7:0] MAX_R = 8'(MAX_ROUNDS);

    typedef enum logic [2:0] {
        SECRET_J1 = 3'd0,
        SECRET_J2 = 3'd1,
        GUESS_J1  = 3'd2,
        GUESS_J2  = 3'd3,
        GAME_OVER = 3'd4
    } state_t;

    state_t state_q, state_d;
    logic   conf_q1, conf_q2;
    logic [GW-1:0] guess_q;
    logic [GW-1:0] secret_j1_q, secret_j1_d, secret_j2_q, secret_j2_d;
    logic [7:0]    round_q, round_d;
    logic [1:0]    winner_q, winner_d;
    logic          j1_hit_q, j1_hit_d;
    logic [CW-1:0] bulls_q, bulls_d, cows_q, cows_d;
    logic          result_valid_q, result_valid_d;
    logic          reject_q, reject_d;
    logic [SCORE_W-1:0] score_j1_q, score_j1_d, score_j2_q, score_j2_d;

    logic          tick;
    logic          legal_c;
    logic [GW-1:0] opp_secret;
    logic [CW-1:0] bulls_c, cows_c;
    logic          hit_c;

    assign tick = conf_q1 & ~conf_q2;

    always_comb begin
        legal_c = 1'b1;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            if ({1'b0, guess_q[i*DIGIT_W +: DIGIT_W]} >= BASE_L)
                legal_c = 1'b0;
            for (int unsigned j = i + 1; j < N_DIGITS; j++) begin
                if (guess_q[i*DIGIT_W +: DIGIT_W] == guess_q[j*DIGIT_W +: DIGIT_W])
                    legal_c = 1'b0;
            end
        end
    end

    // J1 guesses against J2's secret and vice versa.
    always_comb begin
        opp_secret = (state_q == GUESS_J1) ? secret_j2_q : secret_j1_q;
        bulls_c = '0;
        cows_c  = '0;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            for (int unsigned j = 0; j < N_DIGITS; j++) begin
                if (guess_q[i*DIGIT_W +: DIGIT_W] == opp_secret[j*DIGIT_W +: DIGIT_W]) begin
                    if (i == j) bulls_c = bulls_c + CW'(1);
                    else        cows_c  = cows_c + CW'(1);
                end
            end
        end
        hit_c = (bulls_c == CW'(N_DIGITS));
    end

    always_comb begin
        state_d        = state_q;
        secret_j1_d    = secret_j1_q;
        secret_j2_d    = secret_j2_q;
        round_d        = round_q;
        winner_d       = winner_q;
        j1_hit_d       = j1_hit_q;
        bulls_d        = bulls_q;
        cows_d         = cows_q;
        result_valid_d = 1'b0;
        reject_d       = 1'b0;
        score_j1_d     = score_j1_q;
        score_j2_d     = score_j2_q;

        if (tick) begin
            unique case (state_q)
                SECRET_J1: begin
                    if (legal_c) begin
                        secret_j1_d = guess_q;
                        state_d     = SECRET_J2;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
                SECRET_J2: begin
                    if (legal_c) begin
                        secret_j2_d = guess_q;
                        round_d     = 8'd1;
                        j1_hit_d    = 1'b0;
                        state_d     = GUESS_J1;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
                // j1_hit doubles as the final-turn flag: J2 always gets a reply.
                GUESS_J1: begin
                    if (legal_c) begin
                        bulls_d        = bulls_c;
                        cows_d         = cows_c;
                        result_valid_d = 1'b1;
                        if (hit_c) j1_hit_d = 1'b1;
                        state_d = GUESS_J2;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
                GUESS_J2: begin
                    if (legal_c) begin
                        bulls_d        = bulls_c;
                        cows_d         = cows_c;
                        result_valid_d = 1'b1;
                        if (hit_c || j1_hit_q) begin
                            state_d = GAME_OVER;
                            if (hit_c && j1_hit_q) begin
                                winner_d = 2'd3;
                            end else if (hit_c) begin
                                winner_d = 2'd2;
                                if (score_j2_q != '1) score_j2_d = score_j2_q + SCORE_W'(1);
                            end else begin
                                winner_d = 2'd1;
                                if (score_j1_q != '1) score_j1_d = score_j1_q + SCORE_W'(1);
                            end
                        end else if (round_q == MAX_R) begin
                            winner_d = 2'd3;
                            state_d  = GAME_OVER;
                        end else begin
                            round_d = round_q + 8'd1;
                            state_d = GUESS_J1;
                        end
                    end else begin
                        reject_d = 1'b1;
                    end
                end
                GAME_OVER: begin
                    round_d  = '0;
                    winner_d = '0;
                    j1_hit_d = 1'b0;
                    bulls_d  = '0;
                    cows_d   = '0;
                    state_d  = SECRET_J1;
                end
                default: state_d = SECRET_J1;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            conf_q1        <= 1'b0;
            conf_q2        <= 1'b0;
            guess_q        <= '0;
            state_q        <= SECRET_J1;
            secret_j1_q    <= '0;
            secret_j2_q    <= '0;
            round_q        <= '0;
            winner_q       <= '0;
            j1_hit_q       <= 1'b0;
            bulls_q        <= '0;
            cows_q         <= '0;
            result_valid_q <= 1'b0;
            reject_q       <= 1'b0;
            score_j1_q     <= '0;
            score_j2_q     <= '0;
        end else begin
            conf_q1        <= confirm;
            conf_q2        <= conf_q1;
            guess_q        <= guess;
            state_q        <= state_d;
            secret_j1_q    <= secret_j1_d;
            secret_j2_q    <= secret_j2_d;
            round_q        <= round_d;
            winner_q       <= winner_d;
            j1_hit_q       <= j1_hit_d;
            bulls_q        <= bulls_d;
            cows_q         <= cows_d;
            result_valid_q <= result_valid_d;
            reject_q       <= reject_d;
            score_j1_q     <= score_j1_d;
            score_j2_q     <= score_j2_d;
        end
    end

    assign state        = state_q;
    assign bulls        = bulls_q;
    assign cows         = cows_q;
    assign result_valid = result_valid_q;
    assign reject       = reject_q;
    assign round        = round_q;
    assign winner       = winner_q;
    assign score_j1     = score_j1_q;
    assign score_j2     = score_j2_q;

endmodule
